alu_writeback_stage: RTL and testbench
======================================

// Module: alu_writeback_stage
// PURPOSE
//  Stage directly downstream of the ALU: accepts one ALU result per valid
//  instruction, holds the architectural flag register (Carry/Zero/LessThan/AddFlag)
//  that feeds back to the ALU's CarryIn/Z/L/F, and drives the register-file write port.
//  Opcodes 14 (store) and 15 (load) use Rslt as address for a req/ack data-memory
//  access, with a timeout.
// PARAMETERS
//  DW       8   data / address width
//  RW       3   register-file address width
//  TIMEOUT  15  max cycles MemReq may stay high without MemAck (>=2)
// PORTS
//  Clk        in   1   clock, all state on rising edge
//  Reset_n    in   1   asynchronous, active-low reset
//  InValid    in   1   ALU result / op fields valid this cycle
//  InReady    out  1   stage can accept (combinational: state==IDLE)
//  Aluop      in   4   opcode of the instruction in the ALU
//  Rslt       in   DW  ALU result (memory address for ops 14/15)
//  SCo        in   1   ALU carry out
//  Zero       in   1   ALU zero flag
//  LessThan   in   1   ALU less-than flag
//  AddFlag    in   1   ALU add flag
//  DstReg     in   RW  destination register
//  StoreData  in   DW  data to write for op 14
//  CarryFlag  out  1   registered flags -> ALU CarryIn
//  ZeroFlag   out  1   -> ALU Z
//  LtFlag     out  1   -> ALU L
//  AddFlagQ   out  1   -> ALU F
//  RegWrEn    out  1   register-file write strobe (one-cycle pulse)
//  RegWrAddr  out  RW  register-file write address
//  RegWrData  out  DW  register-file write data
//  MemReq     out  1   memory request, held until MemAck or timeout
//  MemWe      out  1   1=write (store), 0=read (load); valid while MemReq
//  MemAddr    out  DW  latched Rslt; MemWdata out DW latched StoreData
//  MemRdata   in   DW  read data, sampled in the MemAck cycle
//  MemAck     in   1   memory completion; ignored unless state==MEM
//  MemErr     out  1   sticky timeout error, cleared only by reset
// BEHAVIOUR
//  Reset: state=IDLE; all outputs/flags/counter 0; MemReq drops immediately
//   (async), even mid-access; the pending op is discarded, no write-back.
//  Accept = InValid & InReady. On accept, all four flags take SCo/Zero/LessThan/
//   AddFlag. The ALU passes through unaffected flags, so unconditional capture is correct.
//  States: IDLE, MEM.
//  IDLE, accept, Aluop 0/9 (branch): flags only; no RegWrEn.
//  IDLE, accept, Aluop 7/8 (compare): flags only; no RegWrEn.
//  IDLE, accept, Aluop 1-6,10-13: next cycle RegWrEn=1, RegWrAddr=DstReg,
//   RegWrData=Rslt; stay IDLE; back-to-back accepts at 1 op/cycle.
//  IDLE, accept, Aluop 14/15: latch MemAddr=Rslt, MemWdata=StoreData,
//   MemWe=(op==14), and DstReg; go MEM.
//  MEM: MemReq=1 from the cycle after accept. Counter increments each MEM cycle.
//  MEM, MemAck=1: MemReq=0 next cycle; go IDLE.
//   Load: RegWrEn pulse next cycle, data=MemRdata sampled at ack.
//   Store: no RegWrEn.
//  MEM, no ack, counter==TIMEOUT-1: MemReq=0, MemErr=1, go IDLE, no write-back.
//   Ack in the same cycle as timeout wins: normal completion, no error.
//  Latency: ALU op accept T -> RegWrEn T+1.
//   Load accept T -> MemReq T+1..A (A = ack cycle) -> RegWrEn A+1; InReady=1 at A+1.
//  RegWrEn is 0 in every cycle not listed above. RegWrAddr/Data hold last value.
//  InValid while InReady=0: upstream holds; nothing captured, flags unchanged.
// TESTING
//  Reset_n=0 mid-op -> all outputs 0, MemReq low same cycle; after release IDLE, InReady=1.
//  Op1, Rslt=8'h05, SCo=1, DstReg=3 -> next cycle RegWrEn=1, addr 3, data 05, CarryFlag=1.
//  Op7, Zero=1, LessThan=0 -> ZeroFlag=1, LtFlag=0, no RegWrEn; CarryFlag unchanged.
//  Op15, Rslt=8'h40, ack 3 cycles later with MemRdata=8'hA5 -> MemReq 3 cycles,
//   MemWe=0, MemAddr=40; RegWrEn with A5 one cycle after ack.
//  Op14, StoreData=8'h3C, no ack -> MemReq high exactly TIMEOUT cycles, MemWe=1,
//   then MemErr=1 sticky, no RegWrEn; next op accepted.
//  Five back-to-back op10 with InValid held 1 -> five consecutive RegWrEn pulses,
//   InReady stays 1.

Source files
------------

// File: rtl/alu_writeback_stage_if.sv
// Bundle between the ALU writeback stage, its upstream ALU, the register-file write port and the data memory.
// The stage uses the slave modport. The environment driving the stage uses the master modport.
interface alu_writeback_stage_if #(
    parameter int DW = 8,
    parameter int RW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    aluop;
    logic [DW-1:0] rslt;
    logic          sco;
    logic          zero;
    logic          less_than;
    logic          add_flag;
    logic [RW-1:0] dst_reg;
    logic [DW-1:0] store_data;

    logic          carry_flag;
    logic          zero_flag;
    logic          lt_flag;
    logic          add_flag_q;

    logic          reg_wr_en;
    logic [RW-1:0] reg_wr_addr;
    logic [DW-1:0] reg_wr_data;

    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          mem_err;

    modport master (
        output in_valid, aluop, rslt, sco, zero, less_than, add_flag, dst_reg, store_data,
        output mem_rdata, mem_ack,
        input  in_ready, carry_flag, zero_flag, lt_flag, add_flag_q,
        input  reg_wr_en, reg_wr_addr, reg_wr_data,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_err
    );

    modport slave (
        input  in_valid, aluop, rslt, sco, zero, less_than, add_flag, dst_reg, store_data,
        input  mem_rdata, mem_ack,
        output in_ready, carry_flag, zero_flag, lt_flag, add_flag_q,
        output reg_wr_en, reg_wr_addr, reg_wr_data,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_err
    );
endinterface

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage. It holds the architectural flags, writes ALU results to the register file,
// and runs load/store accesses with a req/ack handshake and a timeout.
module alu_writeback_stage #(
    parameter int DW      = 8,
    parameter int RW      = 3,
    parameter int TIMEOUT = 15
) (
    input logic                  clk,
    input logic                  rst_n,
    alu_writeback_stage_if.slave bus
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        IDLE,
        MEM
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [RW-1:0] mem_dst;
    logic          accept;

    assign bus.in_ready = (state == IDLE);
    assign accept       = bus.in_valid && (state == IDLE);

    // Flags are captured on every accept: the ALU already passes through the flags an op leaves alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            mem_dst         <= '0;
            bus.carry_flag  <= 1'b0;
            bus.zero_flag   <= 1'b0;
            bus.lt_flag     <= 1'b0;
            bus.add_flag_q  <= 1'b0;
            bus.reg_wr_en   <= 1'b0;
            bus.reg_wr_addr <= '0;
            bus.reg_wr_data <= '0;
            bus.mem_req     <= 1'b0;
            bus.mem_we      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.mem_err     <= 1'b0;
        end else begin
            bus.reg_wr_en <= 1'b0;
            if (accept) begin
                bus.carry_flag <= bus.sco;
                bus.zero_flag  <= bus.zero;
                bus.lt_flag    <= bus.less_than;
                bus.add_flag_q <= bus.add_flag;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (bus.aluop)
                            4'd14, 4'd15: begin
                                bus.mem_addr  <= bus.rslt;
                                bus.mem_wdata <= bus.store_data;
                                bus.mem_we    <= (bus.aluop == 4'd14);
                                bus.mem_req   <= 1'b1;
                                mem_dst       <= bus.dst_reg;
                                cnt           <= '0;
                                state         <= MEM;
                            end
                            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                            4'd10, 4'd11, 4'd12, 4'd13: begin
                                bus.reg_wr_en   <= 1'b1;
                                bus.reg_wr_addr <= bus.dst_reg;
                                bus.reg_wr_data <= bus.rslt;
                            end
                            default: ;
                        endcase
                    end
                end
                MEM: begin
                    // An ack in the timeout cycle still completes the access normally.
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        state       <= IDLE;
                        if (!bus.mem_we) begin
                            bus.reg_wr_en   <= 1'b1;
                            bus.reg_wr_addr <= mem_dst;
                            bus.reg_wr_data <= bus.mem_rdata;
                        end
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        bus.mem_req <= 1'b0;
                        bus.mem_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_writeback_stage.sv
// Self-checking bench for alu_writeback_stage: directed vectors, hand-written memory sequences,
// and randomized traffic checked against a behavioural model.
module tb_alu_writeback_stage;
    localparam int TIMEOUT = 15;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic errSticky;
    logic [3:0] expFlags;

    alu_writeback_stage_if #(.DW(8), .RW(3)) bus ();

    alu_writeback_stage #(.DW(8), .RW(3), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] rslt;
        logic [3:0] flagsIn;
        logic [2:0] dst;
        logic       expWr;
        logic [3:0] expFlags;
    } vec_t;

    vec_t vecs[8];

    function automatic logic writesReg(input logic [3:0] op);
        return (op inside {[4'd1:4'd6], [4'd10:4'd13]});
    endfunction

    function automatic logic [3:0] flagsNow();
        return {bus.carry_flag, bus.zero_flag, bus.lt_flag, bus.add_flag_q};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [7:0] rslt, input logic [3:0] f,
                                 input logic [2:0] dst, input logic [7:0] sdata);
        bus.in_valid   = 1'b1;
        bus.aluop      = op;
        bus.rslt       = rslt;
        {bus.sco, bus.zero, bus.less_than, bus.add_flag} = f;
        bus.dst_reg    = dst;
        bus.store_data = sdata;
    endtask

    // One load/store. The ack arrives in the d-th request cycle. If d exceeds TIMEOUT, the access times out.
    task automatic memOp(input logic [3:0] op, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [7:0] rdata, input int d, input logic [2:0] dst);
        logic [3:0] f;
        int         k;
        int         reqCycles;
        int         strayWr;
        int         expReq;
        logic       expWr;
        f = 4'($urandom);
        applyStimulus(op, addr, f, dst, wdata);
        step();
        bus.in_valid = 1'b0;
        expFlags = f;
        checkOutput("memInReadyLow", 32'(bus.in_ready), 32'd0);
        checkOutput("memAddr", 32'(bus.mem_addr), 32'(addr));
        checkOutput("memWe", 32'(bus.mem_we), 32'(op == 4'd14));
        if (op == 4'd14) checkOutput("memWdata", 32'(bus.mem_wdata), 32'(wdata));
        reqCycles = 0;
        strayWr   = 0;
        k         = 1;
        while (bus.mem_req && k <= 40) begin
            reqCycles++;
            if (bus.reg_wr_en) strayWr++;
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.aluop    = 4'd1;
            {bus.sco, bus.zero, bus.less_than, bus.add_flag} = 4'($urandom);
            if (k == d) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rdata;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = ~rdata;
            end
            step();
            k++;
        end
        bus.in_valid = 1'b0;
        bus.mem_ack  = 1'b0;
        expReq = (d <= TIMEOUT) ? d : TIMEOUT;
        if (d > TIMEOUT) errSticky = 1'b1;
        expWr = (op == 4'd15) && (d <= TIMEOUT);
        checkOutput("memReqCycles", 32'(reqCycles), 32'(expReq));
        checkOutput("memReqDropped", 32'(bus.mem_req), 32'd0);
        checkOutput("memStrayWrEn", 32'(strayWr), 32'd0);
        checkOutput("memInReadyBack", 32'(bus.in_ready), 32'd1);
        checkOutput("memWrEn", 32'(bus.reg_wr_en), 32'(expWr));
        if (expWr) begin
            checkOutput("loadWrAddr", 32'(bus.reg_wr_addr), 32'(dst));
            checkOutput("loadWrData", 32'(bus.reg_wr_data), 32'(rdata));
        end
        checkOutput("memErr", 32'(bus.mem_err), 32'(errSticky));
        checkOutput("memFlagsHeld", 32'(flagsNow()), 32'(expFlags));
        step();
        checkOutput("memWrEnPulse", 32'(bus.reg_wr_en), 32'd0);
    endtask

    task automatic runRandomAlu(input int n);
        logic [3:0] op;
        logic [7:0] r;
        logic [3:0] f;
        logic [2:0] dst;
        logic       v;
        for (int i = 0; i < n; i++) begin
            op  = 4'($urandom_range(0, 13));
            r   = 8'($urandom);
            f   = 4'($urandom);
            dst = 3'($urandom);
            v   = 1'($urandom_range(0, 1));
            applyStimulus(op, r, f, dst, 8'($urandom));
            bus.in_valid  = v;
            bus.mem_ack   = 1'($urandom_range(0, 1));
            bus.mem_rdata = 8'($urandom);
            step();
            if (v) expFlags = f;
            checkOutput("rndInReady", 32'(bus.in_ready), 32'd1);
            checkOutput("rndFlags", 32'(flagsNow()), 32'(expFlags));
            checkOutput("rndWrEn", 32'(bus.reg_wr_en), 32'(v && writesReg(op)));
            if (v && writesReg(op)) begin
                checkOutput("rndWrAddr", 32'(bus.reg_wr_addr), 32'(dst));
                checkOutput("rndWrData", 32'(bus.reg_wr_data), 32'(r));
            end
        end
        bus.in_valid = 1'b0;
        bus.mem_ack  = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        errSticky = 1'b0;
        expFlags  = 4'd0;
        rst_n     = 1'b0;
        applyStimulus(4'd0, 8'd0, 4'd0, 3'd0, 8'd0);
        bus.in_valid  = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'd0;

        vecs[0] = '{op: 4'd1,  rslt: 8'h05, flagsIn: 4'b1000, dst: 3'd3, expWr: 1'b1, expFlags: 4'b1000};
        vecs[1] = '{op: 4'd7,  rslt: 8'h00, flagsIn: 4'b1100, dst: 3'd5, expWr: 1'b0, expFlags: 4'b1100};
        vecs[2] = '{op: 4'd0,  rslt: 8'h77, flagsIn: 4'b0011, dst: 3'd2, expWr: 1'b0, expFlags: 4'b0011};
        vecs[3] = '{op: 4'd9,  rslt: 8'h12, flagsIn: 4'b1111, dst: 3'd7, expWr: 1'b0, expFlags: 4'b1111};
        vecs[4] = '{op: 4'd8,  rslt: 8'h34, flagsIn: 4'b0000, dst: 3'd1, expWr: 1'b0, expFlags: 4'b0000};
        vecs[5] = '{op: 4'd13, rslt: 8'hFF, flagsIn: 4'b0010, dst: 3'd6, expWr: 1'b1, expFlags: 4'b0010};
        vecs[6] = '{op: 4'd6,  rslt: 8'h00, flagsIn: 4'b0100, dst: 3'd0, expWr: 1'b1, expFlags: 4'b0100};
        vecs[7] = '{op: 4'd10, rslt: 8'h81, flagsIn: 4'b0001, dst: 3'd1, expWr: 1'b1, expFlags: 4'b0001};

        #12;
        checkOutput("rstWrEn", 32'(bus.reg_wr_en), 32'd0);
        checkOutput("rstMemReq", 32'(bus.mem_req), 32'd0);
        checkOutput("rstFlags", 32'(flagsNow()), 32'd0);
        checkOutput("rstMemErr", 32'(bus.mem_err), 32'd0);
        checkOutput("rstMemAddr", 32'(bus.mem_addr), 32'd0);
        checkOutput("rstInReady", 32'(bus.in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].op, vecs[i].rslt, vecs[i].flagsIn, vecs[i].dst, 8'h00);
            step();
            bus.in_valid = 1'b0;
            expFlags = vecs[i].expFlags;
            checkOutput("vecWrEn", 32'(bus.reg_wr_en), 32'(vecs[i].expWr));
            checkOutput("vecFlags", 32'(flagsNow()), 32'(vecs[i].expFlags));
            if (vecs[i].expWr) begin
                checkOutput("vecWrAddr", 32'(bus.reg_wr_addr), 32'(vecs[i].dst));
                checkOutput("vecWrData", 32'(bus.reg_wr_data), 32'(vecs[i].rslt));
            end
            step();
            checkOutput("vecWrEnPulse", 32'(bus.reg_wr_en), 32'd0);
        end

        memOp(4'd15, 8'h40, 8'h00, 8'hA5, 3, 3'd4);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'd10, 8'(8'h20 + i), 4'b0101, 3'(i + 1), 8'h00);
            step();
            expFlags = 4'b0101;
            checkOutput("b2bWrEn", 32'(bus.reg_wr_en), 32'd1);
            checkOutput("b2bWrAddr", 32'(bus.reg_wr_addr), 32'(i + 1));
            checkOutput("b2bWrData", 32'(bus.reg_wr_data), 32'(8'h20 + i));
            checkOutput("b2bInReady", 32'(bus.in_ready), 32'd1);
        end
        bus.in_valid = 1'b0;
        step();
        checkOutput("b2bWrEnEnd", 32'(bus.reg_wr_en), 32'd0);

        memOp(4'd14, 8'h55, 8'h3C, 8'h00, 100, 3'd2);
        memOp(4'd15, 8'h66, 8'h00, 8'h5A, TIMEOUT, 3'd6);
        memOp(4'd14, 8'h77, 8'hC3, 8'h00, 1, 3'd0);

        applyStimulus(4'd2, 8'h9E, 4'b1010, 3'd7, 8'h00);
        step();
        bus.in_valid = 1'b0;
        expFlags = 4'b1010;
        checkOutput("afterErrWrEn", 32'(bus.reg_wr_en), 32'd1);
        checkOutput("afterErrWrData", 32'(bus.reg_wr_data), 32'h9E);
        checkOutput("afterErrSticky", 32'(bus.mem_err), 32'd1);

        // Reset in the middle of a load: the request must drop at once and no write-back may follow.
        applyStimulus(4'd15, 8'h12, 4'b1111, 3'd5, 8'h00);
        step();
        bus.in_valid = 1'b0;
        step();
        checkOutput("midOpReqHigh", 32'(bus.mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midRstMemReq", 32'(bus.mem_req), 32'd0);
        checkOutput("midRstFlags", 32'(flagsNow()), 32'd0);
        checkOutput("midRstMemErr", 32'(bus.mem_err), 32'd0);
        checkOutput("midRstWrEn", 32'(bus.reg_wr_en), 32'd0);
        checkOutput("midRstMemAddr", 32'(bus.mem_addr), 32'd0);
        errSticky = 1'b0;
        expFlags  = 4'd0;
        step();
        rst_n = 1'b1;
        step();
        checkOutput("postRstInReady", 32'(bus.in_ready), 32'd1);
        checkOutput("postRstMemReq", 32'(bus.mem_req), 32'd0);
        checkOutput("postRstWrEn", 32'(bus.reg_wr_en), 32'd0);

        for (int round = 0; round < 15; round++) begin
            runRandomAlu(12);
            memOp(4'($urandom_range(14, 15)), 8'($urandom), 8'($urandom), 8'($urandom),
                  $urandom_range(1, TIMEOUT + 3), 3'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
